// File: rtl/obj_mem_arbiter.sv
// Object-memory port arbiter between the matrix unit (read/write) and the clipping unit
// (read-only), with matrix priority, a clip starvation bound and a timed clip lock.
module obj_mem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 144,
    parameter int MAX_WAIT = 15,
    parameter int LOCK_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mat_req,
    input  logic              mat_we,
    input  logic [ADDR_W-1:0] mat_addr,
    input  logic [DATA_W-1:0] mat_wdata,
    output logic              mat_gnt,
    output logic              mat_rvalid,
    input  logic              clip_req,
    input  logic              clip_lock,
    input  logic [ADDR_W-1:0] clip_addr,
    output logic              clip_gnt,
    output logic              clip_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked,
    output logic              lock_timeout
);

    localparam int CW_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int LW_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_FORCED = 2'd2
    } state_t;

    state_t            state_r;
    logic [CW_W-1:0]   clip_wait_r;
    logic [LW_W-1:0]   lock_wait_r;
    logic              mat_rvalid_r;
    logic              clip_rvalid_r;
    logic              lock_timeout_r;
    logic              mat_gnt_s;
    logic              clip_gnt_s;
    logic              mat_rvalid_s;
    logic              clip_rvalid_s;

    // Grant selection from the live requests and the registered arbitration state.
    always_comb begin
        mat_gnt_s  = 1'b0;
        clip_gnt_s = 1'b0;
        if (!rst_n) begin
            mat_gnt_s  = 1'b0;
            clip_gnt_s = 1'b0;
        end else if (state_r == ST_LOCK) begin
            clip_gnt_s = clip_req;
        end else if (clip_req && (!mat_req || (clip_wait_r == CW_W'(MAX_WAIT)))) begin
            clip_gnt_s = 1'b1;
        end else begin
            mat_gnt_s  = mat_req;
        end
    end

    // Outputs are forced to their reset values for as long as rst_n is low.
    assign mat_gnt       = mat_gnt_s;
    assign clip_gnt      = clip_gnt_s;
    assign mem_en        = mat_gnt_s | clip_gnt_s;
    assign mem_we        = mat_gnt_s & mat_we;
    assign mem_addr      = clip_gnt_s ? clip_addr : mat_addr;
    assign mem_wdata     = mat_wdata;
    assign mat_rvalid_s  = rst_n & mat_rvalid_r;
    assign clip_rvalid_s = rst_n & clip_rvalid_r;
    assign mat_rvalid    = mat_rvalid_s;
    assign clip_rvalid   = clip_rvalid_s;
    // The memory's own output register is the data stage; only qualify it here.
    assign rdata         = (mat_rvalid_s | clip_rvalid_s) ? mem_rdata : {DATA_W{1'b0}};
    assign locked        = rst_n & (state_r == ST_LOCK);
    assign lock_timeout  = rst_n & lock_timeout_r;

    // Arbitration FSM, starvation/lock counters and the read-return owner tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            clip_wait_r    <= {CW_W{1'b0}};
            lock_wait_r    <= {LW_W{1'b0}};
            mat_rvalid_r   <= 1'b0;
            clip_rvalid_r  <= 1'b0;
            lock_timeout_r <= 1'b0;
        end else begin
            mat_rvalid_r   <= mat_gnt_s & ~mat_we;
            clip_rvalid_r  <= clip_gnt_s;
            lock_timeout_r <= 1'b0;

            if (!clip_req || clip_gnt_s) begin
                clip_wait_r <= {CW_W{1'b0}};
            end else if (clip_wait_r != CW_W'(MAX_WAIT)) begin
                clip_wait_r <= clip_wait_r + CW_W'(1);
            end else begin
                clip_wait_r <= clip_wait_r;
            end

            case (state_r)
                ST_IDLE: begin
                    lock_wait_r <= {LW_W{1'b0}};
                    if (clip_gnt_s && clip_lock) begin
                        state_r <= ST_LOCK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    // A voluntary release wins over a coincident timeout.
                    if (!clip_lock) begin
                        state_r     <= ST_IDLE;
                        lock_wait_r <= {LW_W{1'b0}};
                    end else if (lock_wait_r == LW_W'(LOCK_MAX)) begin
                        state_r        <= ST_FORCED;
                        lock_wait_r    <= {LW_W{1'b0}};
                        lock_timeout_r <= 1'b1;
                    end else if (mat_req) begin
                        lock_wait_r <= lock_wait_r + LW_W'(1);
                    end else begin
                        lock_wait_r <= lock_wait_r;
                    end
                end
                ST_FORCED: begin
                    // Stay unlocked until clip_lock is seen low, so a new lock needs a fresh rise.
                    lock_wait_r <= {LW_W{1'b0}};
                    if (!clip_lock) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_FORCED;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    lock_wait_r <= {LW_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obj_mem_arbiter.sv
// Self-checking bench for obj_mem_arbiter: directed vector table, lock corner sequences,
// and randomized traffic against a cycle-level reference model with a shadow memory.
module tb_obj_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 144;
    localparam int MW = 15;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mat_req, mat_we, clip_req, clip_lock;
    logic [AW-1:0] mat_addr, clip_addr, mem_addr;
    logic [DW-1:0] mat_wdata, rdata, mem_wdata, mem_rdata;
    logic          mat_gnt, mat_rvalid, clip_gnt, clip_rvalid;
    logic          mem_en, mem_we, locked, lock_timeout;

    always #5 clk = ~clk;

    obj_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .mat_req(mat_req), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
        .mat_gnt(mat_gnt), .mat_rvalid(mat_rvalid),
        .clip_req(clip_req), .clip_lock(clip_lock), .clip_addr(clip_addr),
        .clip_gnt(clip_gnt), .clip_rvalid(clip_rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked), .lock_timeout(lock_timeout)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        logic [127:0] pat;
        pat = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        init_word = (i == 5) ? 144'habc : {16'(i), pat ^ 128'(i)};
    endfunction

    // Synchronous-read storage array behind the arbiter.
    logic [DW-1:0] mem [0:31];
    logic          load_mem;
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state (mode: 0 idle, 1 locked, 2 forced-unlocked).
    int            m_mode, m_cw, m_lw;
    bit            m_mrv, m_crv, m_to;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [0:31];
    bit            e_mg, e_cg;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic predict();
        e_mg = 1'b0;
        e_cg = 1'b0;
        if (rst_n) begin
            if (m_mode == 1) e_cg = clip_req;
            else if (mat_req && clip_req) begin
                if (m_cw >= MW) e_cg = 1'b1;
                else            e_mg = 1'b1;
            end else begin
                e_mg = mat_req;
                e_cg = clip_req;
            end
        end
    endtask

    task automatic compare();
        chk("mat_gnt", mat_gnt, e_mg);
        chk("clip_gnt", clip_gnt, e_cg);
        chk("both_gnt", mat_gnt & clip_gnt, 1'b0);
        chk("mem_en", mem_en, e_mg | e_cg);
        chk("mem_we", mem_we, e_mg & mat_we);
        if (e_mg | e_cg) chk("mem_addr", mem_addr, e_cg ? clip_addr : mat_addr);
        if (e_mg & mat_we) chk("mem_wdata", mem_wdata, mat_wdata);
        chk("mat_rvalid", mat_rvalid, rst_n & m_mrv);
        chk("clip_rvalid", clip_rvalid, rst_n & m_crv);
        chk("rdata", rdata, (rst_n && (m_mrv || m_crv)) ? m_rdata : '0);
        chk("locked", locked, rst_n && (m_mode == 1));
        chk("lock_timeout", lock_timeout, rst_n & m_to);
    endtask

    task automatic advance();
        if (!rst_n) begin
            m_mode = 0; m_cw = 0; m_lw = 0;
            m_mrv = 0; m_crv = 0; m_to = 0; m_rdata = '0;
        end else begin
            m_mrv = e_mg && !mat_we;
            m_crv = e_cg;
            m_to  = 0;
            if (e_cg)                    m_rdata = ref_mem[clip_addr];
            else if (e_mg && !mat_we)    m_rdata = ref_mem[mat_addr];
            if (e_mg && mat_we)          ref_mem[mat_addr] = mat_wdata;
            if (clip_req && !e_cg) m_cw = (m_cw < MW) ? m_cw + 1 : MW;
            else                   m_cw = 0;
            case (m_mode)
                0: if (e_cg && clip_lock) m_mode = 1;
                1: begin
                    if (!clip_lock) begin m_mode = 0; m_lw = 0; end
                    else if (m_lw == LM) begin m_mode = 2; m_to = 1; m_lw = 0; end
                    else if (mat_req) m_lw++;
                end
                2: if (!clip_lock) m_mode = 0;
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic pre();
        #2;
        predict();
        compare();
    endtask

    task automatic post();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic drive(input bit r, input bit mq, input bit mw, input int ma,
                         input bit cq, input bit cl, input int ca);
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rst_n = r; mat_req = mq; mat_we = mw; mat_addr = ma[AW-1:0];
        clip_req = cq; clip_lock = cl; clip_addr = ca[AW-1:0];
        mat_wdata = w[DW-1:0];
    endtask

    typedef struct packed {
        bit r, mq, mw; logic [AW-1:0] ma;
        bit cq, cl; logic [AW-1:0] ca;
        bit mg, cg, mrv, crv, lk;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int  n;
        bit  got;
        bit  mq, mw, cq, cl;
        int  ma, ca;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        m_mode = 0; m_cw = 0; m_lw = 0; m_mrv = 0; m_crv = 0; m_to = 0; m_rdata = '0;
        e_mg = 0; e_cg = 0;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        load_mem = 1'b1;
        @(posedge clk);
        #1;
        load_mem = 1'b0;

        // Directed vectors: single read, alternating owners, lock rising while matrix wins.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].r, tbl[i].mq, tbl[i].mw, int'(tbl[i].ma),
                  tbl[i].cq, tbl[i].cl, int'(tbl[i].ca));
            pre();
            chk("vec_mat_gnt", mat_gnt, tbl[i].mg);
            chk("vec_clip_gnt", clip_gnt, tbl[i].cg);
            chk("vec_mat_rvalid", mat_rvalid, tbl[i].mrv);
            chk("vec_clip_rvalid", clip_rvalid, tbl[i].crv);
            chk("vec_locked", locked, tbl[i].lk);
            if (i == 2) chk("vec_rdata_abc", rdata, 144'habc);
            post();
        end

        // Lock timeout: pending matrix write is blocked until the forced release.
        drive(1'b1, 1'b1, 1'b1, 9, 1'b1, 1'b1, 3);
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            pre();
            if (mat_gnt === 1'b1) begin
                got = 1'b1;
                chk("timeout_with_gnt", lock_timeout, 1'b1);
                chk("forced_unlocked", locked, 1'b0);
            end else begin
                n++;
            end
            post();
        end
        chk("timeout_reached", got, 1'b1);
        chk("blocked_cycles", n, LM);

        // Forced mode ignores a held clip_lock; a re-lock needs it to drop and rise.
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 3);
        for (int k = 0; k < 3; k++) begin
            pre(); chk("no_relock", locked, 1'b0); post();
        end
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3);
        pre(); post();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 3);
        pre(); post();
        pre(); chk("relock", locked, 1'b1); post();

        // Voluntary release after 4 locked cycles with a matrix write pending.
        drive(1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1, 4);
        for (int k = 0; k < 4; k++) begin
            pre(); chk("lock_blocks_mat", mat_gnt, 1'b0); post();
        end
        drive(1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b0, 4);
        pre(); chk("release_cycle_mat", mat_gnt, 1'b0); post();
        pre();
        chk("mat_after_release", mat_gnt, 1'b1);
        chk("no_timeout_on_release", lock_timeout, 1'b0);
        post();

        // Reset in the cycle after a read grant drops the pending rvalid.
        drive(1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0, 0);
        pre(); post();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        pre();
        chk("rst_mat_rvalid", mat_rvalid, 1'b0);
        chk("rst_rdata", rdata, '0);
        post();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 2);
        pre(); chk("post_rst_mat_rvalid", mat_rvalid, 1'b0); chk("post_rst_idle", locked, 1'b0); post();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        pre(); post();

        // Randomized traffic: requests held until granted, occasional cancel, lock and reset.
        mq = 0; mw = 0; ma = 0; cq = 0; ca = 0; cl = 0;
        for (int c = 0; c < 3000; c++) begin
            bit keep_m, keep_c, r;
            r = ($urandom_range(0, 299) != 0);
            keep_m = mq && !e_mg && ($urandom_range(0, 19) != 0);
            keep_c = cq && !e_cg && ($urandom_range(0, 19) != 0);
            if (!keep_m) begin
                mq = ($urandom_range(0, 1) == 1);
                mw = ($urandom_range(0, 2) == 0);
                ma = int'($urandom_range(0, 31));
            end
            if (!keep_c) begin
                cq = ($urandom_range(0, 1) == 1);
                ca = int'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 29) == 0) cl = !cl;
            if (keep_m) begin
                rst_n = r; clip_req = cq; clip_lock = cl; clip_addr = ca[AW-1:0];
            end else begin
                drive(r, mq, mw, ma, cq, cl, ca);
            end
            pre();
            post();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
